// File: rtl/knn_vote_reader.sv
// Reader end of the K-nearest-neighbour list: counts per-class votes and picks the winner.
// Optional distance weighting (entry i adds K-i) enabled by defining KNN_WEIGHTED_VOTE_EN.

module knn_vote_cnt #(
  parameter int VOTE_W = 4,
  parameter int IDX_W  = 2,
  parameter int FI_W   = 3,
  parameter int K      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              hit,
  input  logic [VOTE_W-1:0] weight,
  input  logic [IDX_W-1:0]  idx,
  output logic [VOTE_W-1:0] vote,
  output logic [FI_W-1:0]   first
);
  // first == K means the class has not been seen yet
  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      vote  <= '0;
      first <= FI_W'(K);
    end else if (hit) begin
      vote <= vote + weight;
      if (FI_W'(idx) < first) first <= FI_W'(idx);
    end
  end
endmodule

module knn_vote_reader #(
  parameter int K      = 4,
  parameter int C      = 10,
  parameter int LBL_W  = 8,
  parameter int VOTE_W = 4,
  parameter int IDX_W  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [K*LBL_W-1:0] nb_label,
  input  logic [K-1:0]       nb_valid,
  output logic               busy,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LBL_W-1:0]   out_label,
  output logic [VOTE_W-1:0]  out_votes,
  output logic               out_empty,
  output logic               out_badlbl
);
  localparam int FI_W = IDX_W + 1;
  localparam int CI_W = (C > 1) ? $clog2(C) : 1;
  localparam logic [LBL_W-1:0] C_LBL    = LBL_W'(C);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(K - 1);
  localparam logic [CI_W-1:0]  LAST_CLS = CI_W'(C - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_COUNT, S_SELECT, S_OUT} state_t;
  state_t state, state_nxt;

  logic load, count_en, sel_en;

  logic [K-1:0][LBL_W-1:0] lbl_q;
  logic [K-1:0]            vld_q;
  logic [IDX_W-1:0]        idx;
  logic [CI_W-1:0]         cidx;

  logic [C-1:0][VOTE_W-1:0] votes;
  logic [C-1:0][FI_W-1:0]   firsts;
  logic [C-1:0]             hits;

  logic [VOTE_W-1:0] best_votes;
  logic [FI_W-1:0]   best_first;
  logic [CI_W-1:0]   best_cls;

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    count_en  = 1'b0;
    sel_en    = 1'b0;
    case (state)
      S_IDLE:   if (start) state_nxt = S_LOAD;
      S_LOAD: begin
        load      = 1'b1;
        state_nxt = S_COUNT;
      end
      S_COUNT: begin
        count_en = 1'b1;
        if (idx == LAST_IDX) state_nxt = S_SELECT;
      end
      S_SELECT: begin
        sel_en = 1'b1;
        if (cidx == LAST_CLS) state_nxt = S_OUT;
      end
      S_OUT:    if (out_ready) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  assign busy      = (state != S_IDLE);
  assign out_valid = (state == S_OUT);

  // ---------------- COUNT: one entry per cycle ----------------
  logic [LBL_W-1:0]  ent_lbl;
  logic              ent_vld, in_range;
  logic [VOTE_W-1:0] weight;

  assign ent_lbl  = lbl_q[idx];
  assign ent_vld  = vld_q[idx];
  assign in_range = (ent_lbl < C_LBL);

`ifdef KNN_WEIGHTED_VOTE_EN
  assign weight = VOTE_W'(K) - VOTE_W'(idx);
`else
  assign weight = VOTE_W'(1);
`endif

  for (genvar c = 0; c < C; c++) begin : g_cls
    assign hits[c] = count_en & ent_vld & in_range & (ent_lbl == LBL_W'(c));
    knn_vote_cnt #(.VOTE_W(VOTE_W), .IDX_W(IDX_W), .FI_W(FI_W), .K(K)) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .clr    (load),
      .hit    (hits[c]),
      .weight (weight),
      .idx    (idx),
      .vote   (votes[c]),
      .first  (firsts[c])
    );
  end

  // ---------------- SELECT: one class per cycle ----------------
  logic [VOTE_W-1:0] cur_votes, nb_votes;
  logic [FI_W-1:0]   cur_first, nb_first;
  logic [CI_W-1:0]   nb_cls;
  logic              upd;

  assign cur_votes = votes[cidx];
  assign cur_first = firsts[cidx];
  // equal totals: the class owning the nearer neighbour wins
  assign upd = (cur_votes > best_votes) ||
               ((cur_votes == best_votes) && (cur_votes != '0) && (cur_first < best_first));
  assign nb_votes = upd ? cur_votes : best_votes;
  assign nb_first = upd ? cur_first : best_first;
  assign nb_cls   = upd ? cidx      : best_cls;

  always_ff @(posedge clk) begin
    if (!rst) begin
      lbl_q      <= '0;
      vld_q      <= '0;
      idx        <= '0;
      cidx       <= '0;
      best_votes <= '0;
      best_first <= FI_W'(K);
      best_cls   <= '0;
      out_label  <= '0;
      out_votes  <= '0;
      out_empty  <= 1'b0;
      out_badlbl <= 1'b0;
    end else begin
      if (load) begin
        lbl_q      <= nb_label;
        vld_q      <= nb_valid;
        idx        <= '0;
        cidx       <= '0;
        best_votes <= '0;
        best_first <= FI_W'(K);
        best_cls   <= '0;
        out_badlbl <= 1'b0;
      end
      if (count_en) begin
        idx <= idx + IDX_W'(1);
        if (ent_vld && !in_range) out_badlbl <= 1'b1;
      end
      if (sel_en) begin
        best_votes <= nb_votes;
        best_first <= nb_first;
        best_cls   <= nb_cls;
        cidx       <= cidx + CI_W'(1);
        if (cidx == LAST_CLS) begin
          out_label <= (nb_votes == '0) ? '0 : LBL_W'(nb_cls);
          out_votes <= nb_votes;
          out_empty <= (nb_votes == '0);
        end
      end
    end
  end
endmodule
